// File: rtl/core_pkg.sv
// Shared types and constants for the data-memory bridge between the
// memory stage and the Avalon-MM data bus.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } dmb_state_t;

  localparam int VEC_LANES = 4;
  localparam int WORD_W    = 32;
  localparam int VEC_W     = VEC_LANES * WORD_W;
  localparam logic [WORD_W-1:0] DMB_ABORT_DATA = 32'hDEADBEEF;

  // Poison every lane the aborted load never received; scalar loads only own lane 0.
  function automatic logic [VEC_W-1:0] abort_fill(input logic [VEC_W-1:0] data,
                                                  input logic [1:0]       first,
                                                  input logic             vector);
    logic [VEC_W-1:0] r;
    r = data;
    for (int i = 0; i < VEC_LANES; i++) begin
      if (i >= int'(first) && (vector || i == 0)) begin
        r[i*WORD_W +: WORD_W] = DMB_ABORT_DATA;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// Memory-stage request/response signals plus the Avalon-MM data bus,
// seen from the bridge (master) and from the core/bus environment (slave).
interface data_mem_bridge_if;
  import core_pkg::*;

  logic                mem_read;
  logic                mem_write;
  logic                mem_vector;
  logic [31:0]         mem_addr;
  logic [VEC_W-1:0]    mem_wdata;
  logic [VEC_W-1:0]    mem_rdata;
  logic                stall_all;

  logic [31:0]         avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [WORD_W-1:0]   avm_writedata;
  logic [3:0]          avm_byteenable;
  logic [WORD_W-1:0]   avm_readdata;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;

  logic                bus_err;
  logic                proto_err;

  modport master (
    input  mem_read, mem_write, mem_vector, mem_addr, mem_wdata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid,
    output mem_rdata, stall_all,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output bus_err, proto_err
  );

  modport slave (
    output mem_read, mem_write, mem_vector, mem_addr, mem_wdata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid,
    input  mem_rdata, stall_all,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  bus_err, proto_err
  );

endinterface

// File: rtl/data_mem_bridge.sv
// Splits 32/128-bit memory-stage loads and stores into 32-bit Avalon-MM beats,
// stalling the pipeline until the access completes or times out.
module data_mem_bridge
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_bridge_if.master    bus
);

  dmb_state_t  state;
  logic [1:0]  beat;
  logic [1:0]  next_beat;
  logic [31:0] tmo_cnt;
  logic        is_write;
  logic        is_vector;
  logic        req;
  logic        last_beat;
  logic        tmo_hit;

  assign req       = bus.mem_read | bus.mem_write;
  assign next_beat = beat + 2'd1;
  assign last_beat = ~is_vector | (beat == 2'(VEC_LANES - 1));
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Combinational so the core freezes in the very cycle the request shows up.
  assign bus.stall_all      = req & (state != DONE);
  assign bus.avm_byteenable = 4'b1111;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      beat              <= '0;
      tmo_cnt           <= '0;
      is_write          <= 1'b0;
      is_vector         <= 1'b0;
      bus.avm_address   <= '0;
      bus.avm_read      <= 1'b0;
      bus.avm_write     <= 1'b0;
      bus.avm_writedata <= '0;
      bus.mem_rdata     <= '0;
      bus.bus_err       <= 1'b0;
      bus.proto_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            beat              <= '0;
            tmo_cnt           <= '0;
            bus.mem_rdata     <= '0;
            is_write          <= bus.mem_write;
            is_vector         <= bus.mem_vector;
            bus.avm_address   <= bus.mem_addr & ~32'h3;
            bus.avm_writedata <= bus.mem_wdata[WORD_W-1:0];
            bus.avm_write     <= bus.mem_write;
            bus.avm_read      <= ~bus.mem_write;
            if (bus.mem_read && bus.mem_write) begin
              bus.proto_err <= 1'b1;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (!bus.avm_waitrequest) begin
            tmo_cnt <= '0;
            if (is_write) begin
              beat <= next_beat;
              if (last_beat) begin
                bus.avm_write <= 1'b0;
                state         <= DONE;
              end else begin
                bus.avm_address   <= bus.avm_address + 32'd4;
                bus.avm_writedata <= bus.mem_wdata[{next_beat, 5'b00000} +: WORD_W];
              end
            end else begin
              bus.avm_read <= 1'b0;
              state        <= WAIT_DATA;
            end
          end else if (tmo_hit) begin
            bus.avm_read  <= 1'b0;
            bus.avm_write <= 1'b0;
            bus.bus_err   <= 1'b1;
            if (!is_write) begin
              bus.mem_rdata <= abort_fill(bus.mem_rdata, beat, is_vector);
            end
            state <= DONE;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        WAIT_DATA: begin
          if (bus.avm_readdatavalid) begin
            tmo_cnt                                  <= '0;
            bus.mem_rdata[{beat, 5'b00000} +: WORD_W] <= bus.avm_readdata;
            beat                                     <= next_beat;
            if (last_beat) begin
              state <= DONE;
            end else begin
              bus.avm_address <= bus.avm_address + 32'd4;
              bus.avm_read    <= 1'b1;
              state           <= ISSUE;
            end
          end else if (tmo_hit) begin
            bus.bus_err   <= 1'b1;
            bus.mem_rdata <= abort_fill(bus.mem_rdata, beat, is_vector);
            state         <= DONE;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed, table-driven bench for data_mem_bridge with a cycle-stepped
// Avalon responder and hand-written reset-abort sequence.
module tb_data_mem_bridge;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_mem_bridge_if bus();

  data_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic         vec;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [31:0]  rbase;
    int           stall_beat;
    int           stall_n;
    int           hang_beat;
    int           exp_stall;
    logic [127:0] exp_rdata;
    logic         exp_bus_err;
    logic         exp_proto_err;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request, answers the bus beat by beat and checks the result in DONE.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] base;
    logic [31:0] exp_addr;
    int          nbeats, beat, waited, stall_cnt, reads, writes, pend_beat, exp_reads;
    logic        pending, done;

    base      = {v.addr[31:2], 2'b00};
    nbeats    = v.vec ? 4 : 1;
    beat      = 0;
    waited    = 0;
    stall_cnt = 0;
    reads     = 0;
    writes    = 0;
    pend_beat = 0;
    pending   = 1'b0;
    done      = 1'b0;

    bus.mem_read   = v.rd;
    bus.mem_write  = v.wr;
    bus.mem_vector = v.vec;
    bus.mem_addr   = v.addr;
    bus.mem_wdata  = v.wdata;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      if (!bus.stall_all) begin
        done = 1'b1;
        exp_reads = v.wr ? 0 : ((v.hang_beat >= 0) ? v.hang_beat + 1 : nbeats);
        checkOutput($sformatf("v%0d_stall_cycles", idx), 128'(stall_cnt), 128'(v.exp_stall));
        checkOutput($sformatf("v%0d_rdata", idx), bus.mem_rdata, v.exp_rdata);
        checkOutput($sformatf("v%0d_bus_err", idx), 128'(bus.bus_err), 128'(v.exp_bus_err));
        checkOutput($sformatf("v%0d_proto_err", idx), 128'(bus.proto_err), 128'(v.exp_proto_err));
        checkOutput($sformatf("v%0d_write_beats", idx), 128'(writes), 128'(v.wr ? nbeats : 0));
        checkOutput($sformatf("v%0d_read_beats", idx), 128'(reads), 128'(exp_reads));
        checkOutput($sformatf("v%0d_done_strobes", idx), {bus.avm_read, bus.avm_write}, 128'(0));
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end else begin
        stall_cnt++;
        if (pending) begin
          pending = 1'b0;
          if (pend_beat != v.hang_beat) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = v.rbase + 32'(pend_beat);
          end
        end
        if (bus.avm_read || bus.avm_write) begin
          exp_addr = base + 32'(4 * beat);
          checkOutput($sformatf("v%0d_strobe_excl", idx), 128'(bus.avm_read & bus.avm_write), 128'(0));
          checkOutput($sformatf("v%0d_strobe_kind", idx), 128'(bus.avm_write), 128'(v.wr));
          checkOutput($sformatf("v%0d_addr_b%0d", idx, beat), 128'(bus.avm_address), 128'(exp_addr));
          if (bus.avm_write) begin
            checkOutput($sformatf("v%0d_wdata_b%0d", idx, beat), 128'(bus.avm_writedata),
                        128'(v.wdata[32*beat +: 32]));
          end
          if (beat == v.stall_beat && waited < v.stall_n) begin
            bus.avm_waitrequest = 1'b1;
            waited++;
          end else begin
            if (bus.avm_read) begin
              reads++;
              pending   = 1'b1;
              pend_beat = beat;
            end else begin
              writes++;
            end
            beat++;
          end
        end
      end
      @(negedge clk);
    end

    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL v%0d_budget: no release of stall_all within 200 cycles", idx);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //          rd    wr    vec   addr          wdata                                   rbase         sb  sn  hang stall exp_rdata                                  berr  perr
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 128'h0_0000_0000_0000_0000_0000_1234_5678, 32'h0,       -1, 0, -1, 2,  128'h0,                                   1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 128'h0,                                  32'h0000_00A0, -1, 0, -1, 9,  128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 128'h44444444_33333333_22222222_11111111, 32'h0,       1,  3, -1, 8,  128'h0,                                   1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0033, 128'h0,                                  32'h5A5A_0000, -1, 0, -1, 3,  128'h00000000_00000000_00000000_5A5A0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 128'h0_0000_0000_0000_0000_0000_CAFE_F00D, 32'h0,       -1, 0, -1, 2,  128'h0,                                   1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0007, 128'h0_0000_0000_0000_0000_0000_0BAD_CAFE, 32'h0,       0,  2, -1, 4,  128'h0,                                   1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0500, 128'h0,                                  32'h1111_0000, 3,  1, -1, 10, 128'h11110003_11110002_11110001_11110000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_0300, 128'h0,                                  32'h0000_00B0, -1, 0, 2,  14, 128'hDEADBEEF_DEADBEEF_000000B1_000000B0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 128'h0_0000_0000_0000_0000_0000_0000_00FF, 32'h0,       -1, 0, -1, 2,  128'h0,                                   1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h0000_0600, 128'h0,                                  32'h0BAD_F00D, -1, 0, -1, 3,  128'h00000000_00000000_00000000_0BADF00D, 1'b0, 1'b0};

    reset                 = 1'b0;
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.mem_vector        = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_wdata         = '0;
    bus.avm_readdata      = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_strobes", {bus.avm_read, bus.avm_write}, 128'(0));
    checkOutput("rst_address", 128'(bus.avm_address), 128'(0));
    checkOutput("rst_writedata", 128'(bus.avm_writedata), 128'(0));
    checkOutput("rst_rdata", bus.mem_rdata, 128'(0));
    checkOutput("rst_flags", {bus.bus_err, bus.proto_err}, 128'(0));
    checkOutput("rst_stall", 128'(bus.stall_all), 128'(0));
    checkOutput("rst_byteenable", 128'(bus.avm_byteenable), 128'hF);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset pulsed while beat 1 of a vector read is waiting on the bus.
    $display("[TB] reset during vector read");
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b0;
    bus.mem_vector = 1'b1;
    bus.mem_addr   = 32'h0000_0400;
    @(negedge clk);
    checkOutput("rr_issue0_read", 128'(bus.avm_read), 128'(1));
    @(negedge clk);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h0000_0077;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b1;
    #1;
    checkOutput("rr_issue1_read", 128'(bus.avm_read), 128'(1));
    checkOutput("rr_issue1_addr", 128'(bus.avm_address), 128'h404);
    reset = 1'b0;
    #1;
    checkOutput("rr_async_strobe", {bus.avm_read, bus.avm_write}, 128'(0));
    checkOutput("rr_async_addr", 128'(bus.avm_address), 128'(0));
    checkOutput("rr_async_rdata", bus.mem_rdata, 128'(0));
    bus.mem_read        = 1'b0;
    bus.mem_vector      = 1'b0;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    reset                 = 1'b1;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h0000_0099;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    @(negedge clk);
    checkOutput("rr_late_rdata", bus.mem_rdata, 128'(0));
    checkOutput("rr_late_stall", 128'(bus.stall_all), 128'(0));
    checkOutput("rr_late_strobes", {bus.avm_read, bus.avm_write}, 128'(0));
    checkOutput("rr_late_flags", {bus.bus_err, bus.proto_err}, 128'(0));

    applyStimulus(vecs[9], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
